// File: rtl/dc1_xbit_scrub_pkg.sv
// dc1_xbit_pkg: shared definitions for the L1 data-cache xbit array.
//   - word geometry: 36-bit word = four 9-bit lanes {parity, data[7:0]},
//     lane i occupies bits [9i+8:9i], even parity (parity = ^data)
//   - scrub FSM state encoding
//   - lane check / lane fix / lane encode helpers, shared by the scrubber
//     and the writer-side encoder so both agree on the lane layout
package dc1_xbit_pkg;

  localparam int unsigned XBIT_WORD_W = 36;
  localparam int unsigned XBIT_LANE_W = 9;
  localparam int unsigned XBIT_LANES  = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WT,
    CHK,
    FIX,
    NXT
  } scrub_state_e;

  // Parity over all nine bits of a lane is zero for a good lane.
  function automatic logic [XBIT_LANES-1:0] xbit_lane_bad(
    input logic [XBIT_WORD_W-1:0] word
  );
    logic [XBIT_LANES-1:0] bad;
    bad = '0;
    for (int unsigned i = 0; i < XBIT_LANES; i++) begin
      bad[i] = ^word[i*XBIT_LANE_W +: XBIT_LANE_W];
    end
    return bad;
  endfunction

  // Replace every masked lane with 9'b0 (data 0, parity 0 is parity-correct).
  function automatic logic [XBIT_WORD_W-1:0] xbit_fix(
    input logic [XBIT_WORD_W-1:0] word,
    input logic [XBIT_LANES-1:0]  mask
  );
    logic [XBIT_WORD_W-1:0] fixed;
    fixed = word;
    for (int unsigned i = 0; i < XBIT_LANES; i++) begin
      if (mask[i]) begin
        fixed[i*XBIT_LANE_W +: XBIT_LANE_W] = '0;
      end
    end
    return fixed;
  endfunction

  // Writer-side encoder: 32 data bits to a parity-protected 36-bit word.
  function automatic logic [XBIT_WORD_W-1:0] xbit_encode(
    input logic [31:0] data
  );
    logic [XBIT_WORD_W-1:0] word;
    word = '0;
    for (int unsigned i = 0; i < XBIT_LANES; i++) begin
      word[i*XBIT_LANE_W +: XBIT_LANE_W] = {^data[i*8 +: 8], data[i*8 +: 8]};
    end
    return word;
  endfunction

endpackage

// File: rtl/dc1_xbit_scrub_if.sv
// dc1_xbit_scrub_if: scrubber <-> xbit array arbiter port bundle.
//   read  : rd_req, rd_addr (to array), rd_gnt, rd_data (from array);
//           rd_data is valid exactly one cycle after rd_req & rd_gnt
//   write : wr_req, wr_addr, wr_data (to array), wr_gnt (from array)
// Modports: master = scrubber side, slave = array/arbiter side.
interface dc1_xbit_scrub_if
  import dc1_xbit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5
);

  logic                   rd_req;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic                   rd_gnt;
  logic [XBIT_WORD_W-1:0] rd_data;

  logic                   wr_req;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [XBIT_WORD_W-1:0] wr_data;
  logic                   wr_gnt;

  modport master (
    output rd_req, rd_addr,
    input  rd_gnt, rd_data,
    output wr_req, wr_addr, wr_data,
    input  wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr,
    output rd_gnt, rd_data,
    input  wr_req, wr_addr, wr_data,
    output wr_gnt
  );

endinterface

// File: rtl/dc1_xbit_lane_chk.sv
// dc1_xbit_lane_chk: combinational lane checker for one xbit word.
//   word     in  36  array word, four {parity, data[7:0]} lanes
//   lane_bad out 4   bit i set when lane [9i+8:9i] fails even parity
module dc1_xbit_lane_chk
  import dc1_xbit_pkg::*;
(
  input  logic [XBIT_WORD_W-1:0] word,
  output logic [XBIT_LANES-1:0]  lane_bad
);

  assign lane_bad = xbit_lane_bad(word);

endmodule

// File: rtl/dc1_xbit_scrub.sv
// dc1_xbit_scrub: background parity checker/scrubber for the L1 D-cache
// xbit array. A start pulse walks every index through the shared read port,
// checks all four lanes and reports failing lanes. Optionally rewrites the
// failing lanes as zero through the shared write port.
//
// Build option: define DC1_XBIT_SCRUB_FIX_EN to compile in the correction
// write (FIX state). Undefined: report-only, write port tied to zero.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    one-cycle pulse, accepted only when idle
//   busy                     high while a pass is in progress
//   done                     one-cycle pulse after the last index
//   arr (master)             array read/write request port
//   snp_wr_en, snp_wr_addr   functional-write snoop; a hit on the index in
//                            flight makes the captured data stale
//   err_valid                one-cycle pulse per failing index
//   err_addr, err_lanes      index and failing-lane mask of that error
//   err_count                errors this pass, saturating
module dc1_xbit_scrub
  import dc1_xbit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ADDR_COUNT = 32,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  dc1_xbit_scrub_if.master      arr,
  input  logic                  snp_wr_en,
  input  logic [ADDR_WIDTH-1:0] snp_wr_addr,
  output logic                  err_valid,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [XBIT_LANES-1:0] err_lanes,
  output logic [CNT_W-1:0]      err_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(ADDR_COUNT - 1);

  scrub_state_e           state;
  scrub_state_e           state_n;
  logic [ADDR_WIDTH-1:0]  idx;
  logic [XBIT_WORD_W-1:0] word;
  logic [XBIT_LANES-1:0]  lane_bad;
  logic                   cancel;
  logic                   cancel_set;
  logic                   snp_hit;
  logic                   last_idx;
  logic                   chk_err;

  dc1_xbit_lane_chk u_lane_chk (
    .word     (word),
    .lane_bad (lane_bad)
  );

  assign snp_hit  = snp_wr_en && (snp_wr_addr == idx);
  assign last_idx = (idx == LAST_IDX);
  // A snoop landing in CHK itself also makes the captured word stale.
  assign chk_err  = (state == CHK) && (|lane_bad) && !cancel && !snp_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    cancel_set = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = RD;
      end
      RD: begin
        if (arr.rd_gnt) begin
          state_n    = WT;
          cancel_set = snp_hit;
        end
      end
      WT: begin
        state_n    = CHK;
        cancel_set = snp_hit;
      end
      CHK: begin
        if (cancel || snp_hit) begin
          state_n = RD;
`ifdef DC1_XBIT_SCRUB_FIX_EN
        end else if (|lane_bad) begin
          state_n = FIX;
`endif
        end else begin
          state_n = NXT;
        end
      end
`ifdef DC1_XBIT_SCRUB_FIX_EN
      FIX: begin
        // A granted write wins over a same-cycle snoop; an ungranted write
        // is abandoned and the index re-read.
        if (arr.wr_gnt) begin
          state_n = NXT;
        end else if (snp_hit) begin
          state_n = RD;
        end
      end
`endif
      NXT: begin
        state_n = last_idx ? IDLE : RD;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      word      <= '0;
      cancel    <= 1'b0;
      done      <= 1'b0;
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_lanes <= '0;
      err_count <= '0;
    end else begin
      done      <= (state == NXT) && last_idx;
      err_valid <= chk_err;

      if ((state == IDLE) && start) begin
        idx       <= '0;
        err_count <= '0;
      end else if (state == NXT) begin
        idx <= last_idx ? '0 : idx + 1'b1;
      end

      if (state == WT) word <= arr.rd_data;

      // Cleared on every RD entry so a re-read starts with fresh data.
      if (state_n == RD) begin
        cancel <= 1'b0;
      end else if (cancel_set) begin
        cancel <= 1'b1;
      end

      if (chk_err) begin
        err_addr  <= idx;
        err_lanes <= lane_bad;
        if (err_count != '1) err_count <= err_count + 1'b1;
      end
    end
  end

  assign busy        = (state != IDLE);
  assign arr.rd_req  = (state == RD);
  assign arr.rd_addr = idx;

`ifdef DC1_XBIT_SCRUB_FIX_EN
  assign arr.wr_req  = (state == FIX);
  assign arr.wr_addr = (state == FIX) ? idx : '0;
  assign arr.wr_data = (state == FIX) ? xbit_fix(word, lane_bad) : '0;
`else
  logic unused_wr_gnt;
  assign unused_wr_gnt = arr.wr_gnt;
  assign arr.wr_req    = 1'b0;
  assign arr.wr_addr   = '0;
  assign arr.wr_data   = '0;
`endif

endmodule

// File: tb/tb_dc1_xbit_scrub.sv
module tb_dc1_xbit_scrub;

  localparam int unsigned AW = 5;
  localparam int unsigned N  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          snp_wr_en;
  logic [AW-1:0] snp_wr_addr;
  logic          err_valid;
  logic [AW-1:0] err_addr;
  logic [3:0]    err_lanes;
  logic [7:0]    err_count;

  int checks   = 0;
  int failures = 0;

  logic [35:0] mem [N];

  dc1_xbit_scrub_if #(.ADDR_WIDTH(AW)) arr ();

  dc1_xbit_scrub #(
    .ADDR_WIDTH (AW),
    .ADDR_COUNT (N),
    .CNT_W      (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .arr         (arr.master),
    .snp_wr_en   (snp_wr_en),
    .snp_wr_addr (snp_wr_addr),
    .err_valid   (err_valid),
    .err_addr    (err_addr),
    .err_lanes   (err_lanes),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  // Array model: data one cycle after an accepted read, all-ones otherwise
  // (all-ones fails parity in every lane).
  always @(posedge clk) begin
    if (arr.rd_req && arr.rd_gnt) arr.rd_data <= mem[arr.rd_addr];
    else                          arr.rd_data <= '1;
  end

  // Monitor logs
  int          rd_n = 0;
  logic [AW-1:0] rd_log [512];
  int          err_n = 0;
  logic [AW-1:0] err_a [64];
  logic [3:0]  err_l [64];
  logic [7:0]  err_c [64];
  int          wr_n = 0;
  logic [AW-1:0] wr_a [64];
  logic [35:0] wr_d [64];
  int          wrreq_cyc = 0;
  int          both_hi = 0;
  int          done_n = 0;

  always @(negedge clk) begin
    if (arr.rd_req && arr.rd_gnt && rd_n < 512) begin
      rd_log[rd_n] = arr.rd_addr;
      rd_n++;
    end
    if (err_valid && err_n < 64) begin
      err_a[err_n] = err_addr;
      err_l[err_n] = err_lanes;
      err_c[err_n] = err_count;
      err_n++;
    end
    if (arr.wr_req) wrreq_cyc++;
    if (arr.wr_req && arr.wr_gnt && wr_n < 64) begin
      wr_a[wr_n] = arr.wr_addr;
      wr_d[wr_n] = arr.wr_data;
      wr_n++;
    end
    if (arr.rd_req && arr.wr_req) both_hi++;
    if (done) done_n++;
  end

  task automatic clear_mem();
    for (int i = 0; i < N; i++) mem[i] = '0;
  endtask

  // Leaves the bench #1 after the edge where busy first rises.
  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < limit && !ok) begin
      @(posedge clk); #1;
      cyc++;
      if (done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    start       = 1'b0;
    snp_wr_en   = 1'b0;
    snp_wr_addr = '0;
    arr.rd_gnt  = 1'b1;
    arr.wr_gnt  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, arr.rd_req, arr.wr_req, err_valid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {busy, done, arr.rd_req, arr.wr_req, err_valid});
    end
    checks++;
    if ({arr.rd_addr, arr.wr_addr, arr.wr_data} !== '0) begin
      failures++;
      $display("FAIL reset_bus: got rd_addr=%0d wr_addr=%0d wr_data=%h expected 0",
               arr.rd_addr, arr.wr_addr, arr.wr_data);
    end
    checks++;
    if ({err_addr, err_lanes, err_count} !== '0) begin
      failures++;
      $display("FAIL reset_err: got addr=%0d lanes=%b count=%0d expected 0",
               err_addr, err_lanes, err_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_clean_pass();
    int cyc, r0, e0, w0, bad;
    bit ok;
    clear_mem();
    r0 = rd_n; e0 = err_n; w0 = wrreq_cyc;
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL clean_busy_rise: got %b expected 1", busy);
    end
    // A second start mid-pass must be ignored.
    cyc = 0; ok = 1'b0;
    while (cyc < 300 && !ok) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == 50);
      if (done) ok = 1'b1;
    end
    start = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL clean_timeout: got no done expected done within 300");
    end
    checks++;
    if (cyc != 128) begin
      failures++;
      $display("FAIL clean_latency: got %0d expected 128", cyc);
    end
    checks++;
    if (err_count !== 8'd0 || err_n != e0) begin
      failures++;
      $display("FAIL clean_errors: got count=%0d events=%0d expected 0", err_count, err_n - e0);
    end
    checks++;
    if (rd_n - r0 != 32) begin
      failures++;
      $display("FAIL clean_read_count: got %0d expected 32", rd_n - r0);
    end
    bad = 0;
    for (int i = 0; i < 32; i++) if (rd_log[(r0 + i) % 512] !== AW'(i)) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL clean_read_order: got %0d out-of-order expected 0", bad);
    end
    checks++;
    if (wrreq_cyc != w0) begin
      failures++;
      $display("FAIL clean_no_write: got %0d wr_req cycles expected 0", wrreq_cyc - w0);
    end
    @(posedge clk); #1;
    checks++;
    if ({done, busy} !== 2'b00) begin
      failures++;
      $display("FAIL clean_done_pulse: got done,busy=%b expected 00", {done, busy});
    end
  endtask

  task automatic test_errors();
    int cyc, e0, w0;
    bit ok;
    clear_mem();
    mem[5] = 36'h0_0000_0100;
    mem[9] = {9'h001, 9'h003, 9'h001, 9'h003};
    e0 = err_n; w0 = wr_n;
    pulse_start();
    wait_done(400, cyc, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL err_timeout: got no done expected done within 400");
    end
    checks++;
    if (err_n - e0 != 2) begin
      failures++;
      $display("FAIL err_events: got %0d expected 2", err_n - e0);
    end else begin
      checks++;
      if (err_a[e0] !== 5'd5 || err_l[e0] !== 4'b0001 || err_c[e0] !== 8'd1) begin
        failures++;
        $display("FAIL err_idx5: got addr=%0d lanes=%b count=%0d expected 5 0001 1",
                 err_a[e0], err_l[e0], err_c[e0]);
      end
      checks++;
      if (err_a[e0+1] !== 5'd9 || err_l[e0+1] !== 4'b1010 || err_c[e0+1] !== 8'd2) begin
        failures++;
        $display("FAIL err_idx9: got addr=%0d lanes=%b count=%0d expected 9 1010 2",
                 err_a[e0+1], err_l[e0+1], err_c[e0+1]);
      end
    end
    checks++;
    if (err_count !== 8'd2) begin
      failures++;
      $display("FAIL err_final_count: got %0d expected 2", err_count);
    end
`ifdef DC1_XBIT_SCRUB_FIX_EN
    checks++;
    if (cyc != 130) begin
      failures++;
      $display("FAIL err_latency: got %0d expected 130", cyc);
    end
    checks++;
    if (wr_n - w0 != 2) begin
      failures++;
      $display("FAIL fix_writes: got %0d expected 2", wr_n - w0);
    end else begin
      checks++;
      if (wr_a[w0] !== 5'd5 || wr_d[w0] !== 36'h0) begin
        failures++;
        $display("FAIL fix_idx5: got addr=%0d data=%h expected 5 000000000", wr_a[w0], wr_d[w0]);
      end
      checks++;
      if (wr_a[w0+1] !== 5'd9 || wr_d[w0+1] !== 36'h0_000C_0003) begin
        failures++;
        $display("FAIL fix_idx9: got addr=%0d data=%h expected 9 0000c0003", wr_a[w0+1], wr_d[w0+1]);
      end
    end
`else
    checks++;
    if (cyc != 128) begin
      failures++;
      $display("FAIL err_latency: got %0d expected 128", cyc);
    end
    checks++;
    if (wr_n != w0 || arr.wr_req !== 1'b0) begin
      failures++;
      $display("FAIL report_only_write: got %0d writes expected 0", wr_n - w0);
    end
`endif
  endtask

  task automatic test_stall();
    int cyc, r0, bad, stall_bad;
    bit ok, found1, found_req;
    clear_mem();
    r0 = rd_n;
    pulse_start();
    found1 = 1'b0;
    for (int k = 0; k < 50 && !found1; k++) begin
      @(negedge clk);
      if (arr.rd_req && arr.rd_gnt && arr.rd_addr == 5'd1) found1 = 1'b1;
    end
    @(posedge clk); #1;
    arr.rd_gnt = 1'b0;
    found_req = 1'b0;
    for (int k = 0; k < 10 && !found_req; k++) begin
      @(negedge clk);
      if (arr.rd_req) found_req = 1'b1;
    end
    stall_bad = 0;
    repeat (7) begin
      if (!(arr.rd_req === 1'b1 && arr.rd_addr === 5'd2)) stall_bad++;
      @(negedge clk);
    end
    arr.rd_gnt = 1'b1;
    wait_done(300, cyc, ok);
    checks++;
    if (!(found1 && found_req)) begin
      failures++;
      $display("FAIL stall_setup: got found1=%b found_req=%b expected 1 1", found1, found_req);
    end
    checks++;
    if (stall_bad != 0) begin
      failures++;
      $display("FAIL stall_hold: got %0d bad cycles expected 0", stall_bad);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stall_timeout: got no done expected done within 300");
    end
    bad = 0;
    for (int i = 0; i < 32; i++) if (rd_log[(r0 + i) % 512] !== AW'(i)) bad++;
    checks++;
    if (rd_n - r0 != 32 || bad != 0) begin
      failures++;
      $display("FAIL stall_reads: got %0d reads %0d out-of-order expected 32 0", rd_n - r0, bad);
    end
  endtask

  task automatic test_snoop();
    int cyc, r0, e0, w0, n4;
    bit ok, found;
    clear_mem();
    mem[4] = 36'h0_0000_0001;
    r0 = rd_n; e0 = err_n; w0 = wrreq_cyc;
    pulse_start();
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (arr.rd_req && arr.rd_gnt && arr.rd_addr == 5'd4) found = 1'b1;
    end
    @(posedge clk); #1;             // WT
    @(posedge clk); #1;             // CHK: functional write to idx 4
    snp_wr_en   = 1'b1;
    snp_wr_addr = 5'd4;
    mem[4]      = '0;
    @(posedge clk); #1;
    snp_wr_en   = 1'b0;
    wait_done(300, cyc, ok);
    checks++;
    if (!(found && ok)) begin
      failures++;
      $display("FAIL snoop_run: got found=%b done=%b expected 1 1", found, ok);
    end
    checks++;
    if (err_n != e0 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL snoop_no_err: got events=%0d count=%0d expected 0 0", err_n - e0, err_count);
    end
    checks++;
    if (wrreq_cyc != w0) begin
      failures++;
      $display("FAIL snoop_no_write: got %0d wr_req cycles expected 0", wrreq_cyc - w0);
    end
    n4 = 0;
    for (int i = r0; i < rd_n; i++) if (rd_log[i % 512] === 5'd4) n4++;
    checks++;
    if (rd_n - r0 != 33 || n4 != 2) begin
      failures++;
      $display("FAIL snoop_reread: got reads=%0d idx4=%0d expected 33 2", rd_n - r0, n4);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, d0, r1;
    bit ok;
    clear_mem();
    mem[1] = 36'h0_0000_0100;
    pulse_start();
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (err_count !== 8'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre_reset: got count=%0d busy=%b expected 1 1", err_count, busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy, done, arr.rd_req, arr.wr_req, err_valid} !== 5'b0 ||
        {arr.rd_addr, arr.wr_addr, arr.wr_data, err_addr, err_lanes, err_count} !== '0) begin
      failures++;
      $display("FAIL mid_reset_values: got busy=%b rd_req=%b rd_addr=%0d count=%0d expected all 0",
               busy, arr.rd_req, arr.rd_addr, err_count);
    end
    d0 = done_n;
    repeat (150) @(posedge clk);
    #1;
    checks++;
    if (done_n != d0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_no_done: got done pulses=%0d busy=%b expected 0 0", done_n - d0, busy);
    end
    r1 = rd_n;
    pulse_start();
    checks++;
    if (arr.rd_req !== 1'b1 || arr.rd_addr !== 5'd0) begin
      failures++;
      $display("FAIL mid_restart: got rd_req=%b rd_addr=%0d expected 1 0", arr.rd_req, arr.rd_addr);
    end
    wait_done(300, cyc, ok);
    checks++;
    if (!ok || rd_n - r1 != 32 || rd_log[r1 % 512] !== 5'd0 || err_count !== 8'd1) begin
      failures++;
      $display("FAIL mid_second_pass: got done=%b reads=%0d first=%0d count=%0d expected 1 32 0 1",
               ok, rd_n - r1, rd_log[r1 % 512], err_count);
    end
  endtask

  initial begin
    test_reset();
    test_clean_pass();
    test_errors();
    test_stall();
    test_snoop();
    test_reset_mid();
    checks++;
    if (both_hi != 0) begin
      failures++;
      $display("FAIL req_exclusive: got %0d overlap cycles expected 0", both_hi);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
